// File: rtl/io_pkg.sv
// Shared constants and types for the board I/O unit: switch/LED widths,
// register offsets below the top of the address space, and the register select.
package io_pkg;

    localparam int SW_WIDTH  = 10;
    localparam int LED_WIDTH = 10;

    localparam int LED_OFS = 0;
    localparam int SW_OFS  = 1;
    localparam int CHG_OFS = 2;

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_LED  = 2'd1,
        REG_SW   = 2'd2,
        REG_CHG  = 2'd3
    } io_reg_e;

endpackage

// File: rtl/io_debounce.sv
// Switch synchroniser plus tick-sampled debounce producing the stable switch state.
// Latency 2 cycles to sync; with IO_DEBOUNCE_EN, D+1..2D+1 more to stable. No backpressure.
module io_debounce
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [SW_WIDTH-1:0] i_sw,
    output logic [SW_WIDTH-1:0] o_sw_stable
);

    logic [SW_WIDTH-1:0] r_sw_meta;
    logic [SW_WIDTH-1:0] r_sw_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= i_sw;
            r_sw_sync <= r_sw_meta;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0]    r_tick_cnt;
    logic [SW_WIDTH-1:0] r_sample;
    logic [SW_WIDTH-1:0] r_sw_stable;
    logic                w_tick;
    logic [SW_WIDTH-1:0] w_agree;

    assign w_tick  = (r_tick_cnt == TICK_LAST);
    // A bit is accepted only when two consecutive ticks saw the same level.
    assign w_agree = ~(r_sw_sync ^ r_sample);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt  <= '0;
            r_sample    <= '0;
            r_sw_stable <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
            if (w_tick) begin
                r_sample    <= r_sw_sync;
                r_sw_stable <= (r_sample & w_agree) | (r_sw_stable & ~w_agree);
            end
        end
    end

    assign o_sw_stable = r_sw_stable;
`else
    logic [31:0] w_unused_cfg;
    assign w_unused_cfg = DEBOUNCE_CYCLES;
    assign o_sw_stable  = r_sw_sync;
`endif

endmodule

// File: rtl/board_io_ctrl.sv
// Memory-mapped board I/O: LED register, debounced switches, sticky change flags.
// Read/write latency 1 cycle; no backpressure. IO_DEBOUNCE_EN enables switch debounce.
module board_io_ctrl
    import io_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 500000
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  io_sel,
    input  logic [SW_WIDTH-1:0]   sw,
    output logic [LED_WIDTH-1:0]  leds
);

    localparam logic [ADDR_WIDTH-1:0] ALL1     = '1;
    localparam logic [ADDR_WIDTH-1:0] LED_ADDR = ALL1 - ADDR_WIDTH'(LED_OFS);
    localparam logic [ADDR_WIDTH-1:0] SW_ADDR  = ALL1 - ADDR_WIDTH'(SW_OFS);
    localparam logic [ADDR_WIDTH-1:0] CHG_ADDR = ALL1 - ADDR_WIDTH'(CHG_OFS);

    io_reg_e               w_sel;
    logic [SW_WIDTH-1:0]   w_sw_stable;
    logic [SW_WIDTH-1:0]   w_chg_set;
    logic                  w_chg_clr;
    logic [DATA_WIDTH-1:0] w_rd_nxt;

    logic [LED_WIDTH-1:0]  r_leds;
    logic [SW_WIDTH-1:0]   r_stable_q;
    logic [SW_WIDTH-1:0]   r_chg;
    logic [DATA_WIDTH-1:0] r_rd_data;

    io_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .i_sw        (sw),
        .o_sw_stable (w_sw_stable)
    );

    always_comb begin
        w_sel = REG_NONE;
        if (addr == LED_ADDR) begin
            w_sel = REG_LED;
        end else if (addr == SW_ADDR) begin
            w_sel = REG_SW;
        end else if (addr == CHG_ADDR) begin
            w_sel = REG_CHG;
        end
    end

    assign io_sel = (w_sel != REG_NONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_leds <= '0;
        end else if (we && (w_sel == REG_LED)) begin
            r_leds <= wr_data[LED_WIDTH-1:0];
        end
    end

    generate
        if (DATA_WIDTH > LED_WIDTH) begin : g_wr_hi
            logic w_unused_wr_hi;
            assign w_unused_wr_hi = ^wr_data[DATA_WIDTH-1:LED_WIDTH];
        end
    endgenerate

    assign w_chg_set = w_sw_stable ^ r_stable_q;
    assign w_chg_clr = re && (w_sel == REG_CHG);

    // A transition arriving together with a clearing read must not be lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable_q <= '0;
            r_chg      <= '0;
        end else begin
            r_stable_q <= w_sw_stable;
            r_chg      <= (r_chg & ~{SW_WIDTH{w_chg_clr}}) | w_chg_set;
        end
    end

    always_comb begin
        w_rd_nxt = '0;
        case (w_sel)
            REG_LED: w_rd_nxt[LED_WIDTH-1:0] = r_leds;
            REG_SW:  w_rd_nxt[SW_WIDTH-1:0]  = w_sw_stable;
            REG_CHG: w_rd_nxt[SW_WIDTH-1:0]  = r_chg;
            default: w_rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (re) begin
            r_rd_data <= w_rd_nxt;
        end
    end

    assign rd_data = r_rd_data;
    assign leds    = r_leds;

endmodule
